// File: rtl/input_script_player_pkg.sv
// Shared types for the scripted button player: mode/state encodings and the
// packed layouts of script and key-map entries at the default configuration.
`default_nettype none
package input_script_pkg;

   localparam int NUM_BUTTONS_DEF = 8;
   localparam int NUM_COLS_DEF    = 8;
   localparam int DELTA_WIDTH_DEF = 24;
   localparam int MAP_COL_W_DEF   = $clog2(NUM_COLS_DEF + 4);
   localparam int K_LINES         = 4;

   typedef enum logic [1:0] {
      MODE_LIVE     = 2'd0,
      MODE_SCRIPT   = 2'd1,
      MODE_BOTH     = 2'd2,
      MODE_LIVE_ALT = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   typedef struct packed {
      logic                       last;
      logic [NUM_BUTTONS_DEF-1:0] mask;
      logic [DELTA_WIDTH_DEF-1:0] delta;
   } script_entry_t;

   typedef struct packed {
      logic                     en;
      logic [MAP_COL_W_DEF-1:0] col;
      logic [1:0]               kbit;
   } map_entry_t;

endpackage
`default_nettype wire

// File: rtl/input_script_player_key_matrix.sv
// Per-button key-map registers and the combinational K-line mux driven by the
// CPU column strobes (S lines, then R[3:0] as four extra columns).
`default_nettype none
module input_key_matrix
   import input_script_pkg::*;
#(
   parameter  int NUM_BUTTONS = NUM_BUTTONS_DEF,
   parameter  int NUM_COLS    = NUM_COLS_DEF,
   localparam int BW          = $clog2(NUM_BUTTONS),
   localparam int CW          = $clog2(NUM_COLS + 4)
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   map_wr_en,
   input  logic [BW-1:0]          map_wr_idx,
   input  logic [CW+2:0]          map_wr_data,
   input  logic [NUM_BUTTONS-1:0] eff_buttons,
   input  logic [NUM_COLS-1:0]    shifter_s,
   input  logic [K_LINES-1:0]     output_r,
   output logic [K_LINES-1:0]     input_k
);

   logic [NUM_BUTTONS-1:0] en_q;
   logic [CW-1:0]          col_q  [NUM_BUTTONS];
   logic [1:0]             kbit_q [NUM_BUTTONS];
   logic                   col_act;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q <= '0;
         for (int b = 0; b < NUM_BUTTONS; b++) begin
            col_q[b]  <= '0;
            kbit_q[b] <= '0;
         end
      end else if (map_wr_en) begin
         en_q[map_wr_idx]   <= map_wr_data[CW+2];
         col_q[map_wr_idx]  <= map_wr_data[CW+1:2];
         kbit_q[map_wr_idx] <= map_wr_data[1:0];
      end
   end

   // No register on this path: the CPU samples K mid-instruction.
   always_comb begin
      input_k = '0;
      col_act = 1'b0;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
         col_act = 1'b0;
         for (int c = 0; c < NUM_COLS; c++)
            if (col_q[b] == CW'(c)) col_act = shifter_s[c];
         for (int r = 0; r < K_LINES; r++)
            if (col_q[b] == CW'(NUM_COLS + r)) col_act = output_r[r];
         if (en_q[b] && eff_buttons[b] && col_act)
            input_k[kbit_q[b]] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/input_script_player.sv
// Script sequencer: replays {wait N retired instructions, set button mask}
// entries from a small RAM and feeds live/scripted buttons to the K matrix.
`default_nettype none
module input_script_player
   import input_script_pkg::*;
#(
   parameter  int NUM_BUTTONS  = NUM_BUTTONS_DEF,
   parameter  int NUM_COLS     = NUM_COLS_DEF,
   parameter  int SCRIPT_DEPTH = 64,
   parameter  int DELTA_WIDTH  = DELTA_WIDTH_DEF,
   localparam int AW           = $clog2(SCRIPT_DEPTH),
   localparam int BW           = $clog2(NUM_BUTTONS),
   localparam int CW           = $clog2(NUM_COLS + 4),
   localparam int EW           = 1 + NUM_BUTTONS + DELTA_WIDTH
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   step_strobe,
   input  logic                   start,
   input  logic                   abort,
   input  logic [1:0]             mode,
   input  logic [NUM_BUTTONS-1:0] live_buttons,
   input  logic                   scr_wr_en,
   input  logic [AW-1:0]          scr_wr_addr,
   input  logic [EW-1:0]          scr_wr_data,
   input  logic                   map_wr_en,
   input  logic [BW-1:0]          map_wr_idx,
   input  logic [CW+2:0]          map_wr_data,
   input  logic [NUM_COLS-1:0]    shifter_s,
   input  logic [K_LINES-1:0]     output_r,
   output logic [K_LINES-1:0]     input_k,
   output logic                   busy,
   output logic                   done,
   output logic [AW-1:0]          cur_index,
   output logic [NUM_BUTTONS-1:0] script_buttons
);

   logic [EW-1:0]          mem_q [SCRIPT_DEPTH];
   logic [EW-1:0]          rd_data_q;
   state_e                 state_q;
   logic [AW-1:0]          cur_index_q;
   logic [NUM_BUTTONS-1:0] script_buttons_q;
   logic [NUM_BUTTONS-1:0] mask_q;
   logic [DELTA_WIDTH-1:0] cnt_q;
   logic                   busy_q, done_q, pending_q, last_q;

   logic                   rd_last;
   logic [NUM_BUTTONS-1:0] rd_mask;
   logic [DELTA_WIDTH-1:0] rd_delta;
   logic [1:0]             dec;
   logic                   apply;
   logic [NUM_BUTTONS-1:0] eff_buttons;

   assign rd_last  = rd_data_q[EW-1];
   assign rd_mask  = rd_data_q[EW-2 -: NUM_BUTTONS];
   assign rd_delta = rd_data_q[DELTA_WIDTH-1:0];

   // A strobe parked during FETCH/LOAD and a fresh one can land together.
   assign dec   = {1'b0, step_strobe} + {1'b0, pending_q};
   assign apply = (cnt_q <= DELTA_WIDTH'(dec));

   always_ff @(posedge clk) begin
      if (scr_wr_en) mem_q[scr_wr_addr] <= scr_wr_data;
      if (state_q == ST_FETCH) rd_data_q <= mem_q[cur_index_q];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         cur_index_q      <= '0;
         script_buttons_q <= '0;
         mask_q           <= '0;
         cnt_q            <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pending_q        <= 1'b0;
         last_q           <= 1'b0;
      end else if (abort) begin
         state_q          <= ST_IDLE;
         cur_index_q      <= '0;
         script_buttons_q <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pending_q        <= 1'b0;
      end else if (start) begin
         state_q          <= ST_FETCH;
         cur_index_q      <= '0;
         script_buttons_q <= '0;
         busy_q           <= 1'b1;
         done_q           <= 1'b0;
         pending_q        <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               pending_q <= step_strobe;
               state_q   <= ST_LOAD;
            end
            ST_LOAD: begin
               cnt_q     <= (pending_q && rd_delta != '0) ? rd_delta - 1'b1 : rd_delta;
               pending_q <= step_strobe;
               last_q    <= rd_last;
               mask_q    <= rd_mask;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               pending_q <= 1'b0;
               if (apply) begin
                  if (last_q || cur_index_q == AW'(SCRIPT_DEPTH - 1)) begin
                     script_buttons_q <= '0;
                     done_q           <= 1'b1;
                     busy_q           <= 1'b0;
                     state_q          <= ST_DONE;
                  end else begin
                     script_buttons_q <= mask_q;
                     cur_index_q      <= cur_index_q + AW'(1);
                     state_q          <= ST_FETCH;
                  end
               end else begin
                  cnt_q <= cnt_q - DELTA_WIDTH'(dec);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      eff_buttons = live_buttons;
      case (mode)
         MODE_SCRIPT: eff_buttons = script_buttons_q;
         MODE_BOTH:   eff_buttons = live_buttons | script_buttons_q;
         default:     eff_buttons = live_buttons;
      endcase
   end

   input_key_matrix #(
      .NUM_BUTTONS (NUM_BUTTONS),
      .NUM_COLS    (NUM_COLS)
   ) u_key_matrix (
      .clk         (clk),
      .reset_n     (reset_n),
      .map_wr_en   (map_wr_en),
      .map_wr_idx  (map_wr_idx),
      .map_wr_data (map_wr_data),
      .eff_buttons (eff_buttons),
      .shifter_s   (shifter_s),
      .output_r    (output_r),
      .input_k     (input_k)
   );

   assign busy           = busy_q;
   assign done           = done_q;
   assign cur_index      = cur_index_q;
   assign script_buttons = script_buttons_q;

endmodule
`default_nettype wire

// File: tb/tb_input_script_player.sv
// Scoreboarded bench for input_script_player: a cycle-counting reference
// model predicts output changes, a monitor pops and compares them.
`default_nettype none
module tb_input_script_player;
   import input_script_pkg::*;

   localparam int NB = 8, NC = 8, DEPTH = 64, AW = 6, BW = 3, CW = 4, EW = 33;

   logic          clk = 1'b0, reset_n = 1'b0;
   logic          step_strobe = 1'b0, start = 1'b0, abort = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [NB-1:0] live_buttons = '0;
   logic          scr_wr_en = 1'b0;
   logic [AW-1:0] scr_wr_addr = '0;
   logic [EW-1:0] scr_wr_data = '0;
   logic          map_wr_en = 1'b0;
   logic [BW-1:0] map_wr_idx = '0;
   logic [CW+2:0] map_wr_data = '0;
   logic [NC-1:0] shifter_s = '0;
   logic [3:0]    output_r = '0;
   logic [3:0]    input_k;
   logic          busy, done;
   logic [AW-1:0] cur_index;
   logic [NB-1:0] script_buttons;

   always #5 clk = ~clk;

   input_script_player dut (
      .clk(clk), .reset_n(reset_n), .step_strobe(step_strobe), .start(start), .abort(abort),
      .mode(mode), .live_buttons(live_buttons), .scr_wr_en(scr_wr_en), .scr_wr_addr(scr_wr_addr),
      .scr_wr_data(scr_wr_data), .map_wr_en(map_wr_en), .map_wr_idx(map_wr_idx),
      .map_wr_data(map_wr_data), .shifter_s(shifter_s), .output_r(output_r), .input_k(input_k),
      .busy(busy), .done(done), .cur_index(cur_index), .script_buttons(script_buttons)
   );

   int tests = 0, fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [7:0] sb; bit done; bit busy; int idx; int cyc; } ev_t;
   ev_t q[$];

   logic [EW-1:0] m_mem [DEPTH];
   bit            m_en [NB];
   int            m_col [NB];
   int            m_kbit [NB];
   bit            m_active, m_done;
   int            m_idx, m_tf, m_cnt, cyc;
   logic [7:0]    m_sb;
   script_entry_t m_entry;

   initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

   // Entry applies at the end of the first cycle >= FETCH+2 by which the
   // strobes seen since its FETCH cycle reach its delta.
   always @(posedge clk) begin
      if (!reset_n) begin
         m_active = 0; m_done = 0; m_idx = 0; m_sb = '0; cyc = 0; m_cnt = 0; m_tf = 0;
         for (int b = 0; b < NB; b++) m_en[b] = 0;
      end else begin
         automatic logic [7:0] o_sb = m_sb;
         automatic bit o_done = m_done, o_busy = m_active;
         automatic int o_idx = m_idx;
         cyc++;
         if (abort) begin
            m_active = 0; m_done = 0; m_idx = 0; m_sb = '0;
         end else if (start) begin
            m_active = 1; m_done = 0; m_idx = 0; m_sb = '0; m_tf = cyc + 1; m_cnt = 0;
         end else if (m_active && cyc >= m_tf) begin
            if (cyc == m_tf) m_entry = m_mem[m_idx];
            m_cnt += int'(step_strobe);
            if (cyc >= m_tf + 2 && m_cnt >= int'(m_entry.delta)) begin
               if (m_entry.last || m_idx == DEPTH - 1) begin
                  m_active = 0; m_done = 1; m_sb = '0;
               end else begin
                  m_sb = m_entry.mask; m_idx++; m_tf = cyc + 1; m_cnt = 0;
               end
            end
         end
         if (scr_wr_en) m_mem[scr_wr_addr] = scr_wr_data;
         if (map_wr_en) begin
            m_en[map_wr_idx]   = map_wr_data[CW+2];
            m_col[map_wr_idx]  = int'(map_wr_data[CW+1:2]);
            m_kbit[map_wr_idx] = int'(map_wr_data[1:0]);
         end
         if (o_sb != m_sb || o_done != m_done || o_busy != m_active || o_idx != m_idx)
            q.push_back('{m_sb, m_done, m_active, m_idx, cyc});
      end
   end

   function automatic logic [3:0] exp_k();
      logic [3:0] k = '0;
      logic [7:0] eff;
      case (mode)
         2'd1:    eff = m_sb;
         2'd2:    eff = live_buttons | m_sb;
         default: eff = live_buttons;
      endcase
      for (int b = 0; b < NB; b++) begin
         if (m_en[b] && eff[b]) begin
            bit act;
            if (m_col[b] < NC)          act = shifter_s[m_col[b]];
            else if (m_col[b] < NC + 4) act = output_r[m_col[b] - NC];
            else                        act = 1'b0;
            if (act) k[m_kbit[b]] = 1'b1;
         end
      end
      return k;
   endfunction

   // ---------------- monitor ----------------
   logic [7:0]    p_sb;
   logic          p_done, p_busy;
   logic [AW-1:0] p_idx;

   always @(negedge clk) begin
      if (!reset_n) begin
         p_sb = '0; p_done = 0; p_busy = 0; p_idx = '0;
      end else begin
         if ({script_buttons, done, busy, cur_index} !== {p_sb, p_done, p_busy, p_idx}) begin
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL out_unexpected: sb=%0h done=%0b busy=%0b idx=%0d at cyc %0d, no change expected",
                        script_buttons, done, busy, cur_index, cyc);
            end else begin
               ev_t e;
               e = q.pop_front();
               check("out_event {cyc,sb,done,busy,idx}",
                     {32'(cyc), script_buttons, done, busy, cur_index},
                     {32'(e.cyc), e.sb, e.done, e.busy, 6'(e.idx)});
            end
            p_sb = script_buttons; p_done = done; p_busy = busy; p_idx = cur_index;
         end
         check("input_k", 64'(input_k), 64'(exp_k()));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(); @(posedge clk); #1; endtask
   task automatic pulse_start(); start = 1; tick(); start = 0; endtask
   task automatic pulse_abort(); abort = 1; tick(); abort = 0; endtask
   task automatic strobe(); step_strobe = 1; tick(); step_strobe = 0; endtask

   task automatic write_entry(input int addr, input bit last, input logic [7:0] mask, input int delta);
      script_entry_t se;
      se.last = last; se.mask = mask; se.delta = 24'(delta);
      scr_wr_en = 1; scr_wr_addr = AW'(addr); scr_wr_data = se;
      tick();
      scr_wr_en = 0;
   endtask

   task automatic write_map(input int idx, input bit en, input int col, input int kbit);
      map_entry_t me;
      me.en = en; me.col = CW'(col); me.kbit = 2'(kbit);
      map_wr_en = 1; map_wr_idx = BW'(idx); map_wr_data = me;
      tick();
      map_wr_en = 0;
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int i = 0; i < budget && done !== 1'b1; i++) tick();
      check(name, 64'(done), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_idx", 64'(cur_index), 64'd0);
      check("rst_sb", 64'(script_buttons), 64'd0);
      reset_n = 1;
      tick();

      // live button through S0 onto K1
      write_map(0, 1, 0, 1);
      mode = 2'd0; live_buttons = 8'h01; shifter_s = 8'h01; #1;
      check("t1_k_s0", 64'(input_k), 64'h2);
      shifter_s = 8'h02; #1;
      check("t1_k_s1", 64'(input_k), 64'h0);
      live_buttons = '0; shifter_s = '0;

      // two-entry script with sparse strobes
      write_entry(0, 0, 8'h01, 3);
      write_entry(1, 1, 8'h00, 2);
      mode = 2'd1;
      pulse_start();
      repeat (3) tick();
      strobe(); repeat (3) tick();
      strobe(); repeat (3) tick();
      check("t2_sb_before", 64'(script_buttons), 64'h00);
      strobe();
      check("t2_sb_3rd", 64'(script_buttons), 64'h01);
      check("t2_busy_mid", 64'(busy), 64'd1);
      repeat (3) tick();
      strobe(); repeat (3) tick();
      strobe();
      check("t2_done", 64'(done), 64'd1);
      check("t2_busy", 64'(busy), 64'd0);
      check("t2_sb_end", 64'(script_buttons), 64'h00);

      // strobes during FETCH and LOAD both count
      write_entry(0, 0, 8'h5A, 2);
      write_entry(1, 1, 8'h00, 0);
      pulse_start();
      step_strobe = 1; tick(); tick(); step_strobe = 0;
      check("t3_not_early", 64'(script_buttons), 64'h00);
      tick();
      check("t3_first_wait", 64'(script_buttons), 64'h5A);
      wait_done("t3_done", 20);

      // full-depth script, no end flags
      for (int i = 0; i < DEPTH; i++) write_entry(i, 0, 8'(i), 0);
      pulse_start();
      wait_done("t4_done", 400);
      check("t4_idx", 64'(cur_index), 64'd63);
      check("t4_busy", 64'(busy), 64'd0);

      // start and abort together: abort wins
      write_entry(0, 0, 8'hFF, 0);
      write_entry(1, 0, 8'h33, 100);
      pulse_start();
      repeat (8) tick();
      check("t5_sb_pre", 64'(script_buttons), 64'hFF);
      start = 1; abort = 1; tick(); start = 0; abort = 0;
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_sb", 64'(script_buttons), 64'h00);
      check("t5_done", 64'(done), 64'd0);
      check("t5_idx", 64'(cur_index), 64'd0);
      pulse_start();
      repeat (5) tick();
      check("t5_replay_sb", 64'(script_buttons), 64'hFF);
      check("t5_replay_idx", 64'(cur_index), 64'd1);
      pulse_abort();

      // scripted button through R3 onto K3
      write_map(2, 1, 11, 3);
      write_entry(0, 0, 8'h04, 0);
      write_entry(1, 1, 8'h00, 1000);
      pulse_start();
      repeat (5) tick();
      mode = 2'd2; live_buttons = '0; output_r = 4'h8; shifter_s = '0; #1;
      check("t6_k_both", 64'(input_k), 64'h8);
      mode = 2'd0; #1;
      check("t6_k_live", 64'(input_k), 64'h0);
      pulse_abort();
      output_r = '0;

      // randomized rounds
      for (int r = 0; r < 6; r++) begin
         automatic int len = 1 + int'($urandom_range(7));
         for (int b = 0; b < NB; b++)
            write_map(b, 1'($urandom_range(1)), int'($urandom_range(15)), int'($urandom_range(3)));
         for (int i = 0; i < len; i++)
            write_entry(i, (i == len - 1) || ($urandom_range(5) == 0), 8'($urandom), int'($urandom_range(4)));
         pulse_start();
         for (int c = 0; c < 300; c++) begin
            step_strobe  = 1'($urandom_range(1));
            start        = ($urandom_range(59) == 0);
            abort        = ($urandom_range(149) == 0);
            mode         = 2'($urandom);
            live_buttons = 8'($urandom);
            shifter_s    = 8'($urandom);
            output_r     = 4'($urandom);
            map_wr_en    = ($urandom_range(39) == 0);
            map_wr_idx   = BW'($urandom);
            map_wr_data  = 7'($urandom);
            tick();
         end
         step_strobe = 0; start = 0; map_wr_en = 0;
         pulse_abort();
      end

      repeat (3) tick();
      check("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
